// File: rtl/ysyx_23060061_core_sequencer_if.sv
// Handshake and status bundle between the core sequencer and the fetch, decode,
// data-memory and register-file logic around it.
interface ysyx_23060061_core_sequencer_if #(
  parameter int unsigned RETIRE_W = 32
);
  logic                imem_req;
  logic                imem_ack;
  logic                ir_we;
  logic                dec_reg_write;
  logic                dec_mem_write;
  logic                dec_mem_read;
  logic                dec_ebreak;
  logic                dmem_req;
  logic                dmem_we;
  logic                dmem_ack;
  logic                reg_we;
  logic                pc_we;
  logic                halt;
  logic                fault;
  logic [RETIRE_W-1:0] retire_cnt;
  logic [2:0]          state;

  modport master (
    output imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, halt, fault,
           retire_cnt, state,
    input  imem_ack, dmem_ack, dec_reg_write, dec_mem_write, dec_mem_read,
           dec_ebreak
  );

  modport slave (
    input  imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, halt, fault,
           retire_cnt, state,
    output imem_ack, dmem_ack, dec_reg_write, dec_mem_write, dec_mem_read,
           dec_ebreak
  );
endinterface

// File: rtl/ysyx_23060061_core_sequencer.sv
// Multi-cycle control sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB, with HALT on ebreak.
// Define YSYX_23060061_MEM_TIMEOUT_EN to add the memory-wait watchdog and FAULT state.
module ysyx_23060061_core_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned RETIRE_W       = 32
) (
  input logic                            clk,
  input logic                            rst,
  ysyx_23060061_core_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [RETIRE_W-1:0] retire_q, retire_d;

  logic imem_req_c, ir_we_c, dmem_req_c, dmem_we_c, reg_we_c, pc_we_c, halt_c;

`ifdef YSYX_23060061_MEM_TIMEOUT_EN
  localparam int unsigned WAIT_W = 8;

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              fault_c;
  logic              wait_expired_c;

  // This waiting cycle is the last one allowed before giving up.
  assign wait_expired_c = (32'(wait_q) + 32'd1) >= TIMEOUT_CYCLES;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      retire_q <= '0;
`ifdef YSYX_23060061_MEM_TIMEOUT_EN
      wait_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      retire_q <= retire_d;
`ifdef YSYX_23060061_MEM_TIMEOUT_EN
      wait_q   <= wait_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    retire_d   = retire_q;
    imem_req_c = 1'b0;
    ir_we_c    = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    reg_we_c   = 1'b0;
    pc_we_c    = 1'b0;
    halt_c     = 1'b0;
`ifdef YSYX_23060061_MEM_TIMEOUT_EN
    fault_c    = 1'b0;
    wait_d     = wait_q;
`endif
    case (state_q)
      ST_FETCH: begin
        imem_req_c = 1'b1;
        if (bus.imem_ack) begin
          ir_we_c = 1'b1;
          state_d = ST_DECODE;
        end
`ifdef YSYX_23060061_MEM_TIMEOUT_EN
        else if (wait_expired_c) begin
          state_d = ST_FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
`endif
      end
      ST_DECODE: begin
        state_d = bus.dec_ebreak ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        if (bus.dec_mem_read | bus.dec_mem_write) begin
          state_d = ST_MEM;
`ifdef YSYX_23060061_MEM_TIMEOUT_EN
          wait_d  = '0;
`endif
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        // A read+write decode is a store: the write qualifier alone decides.
        dmem_req_c = 1'b1;
        dmem_we_c  = bus.dec_mem_write;
        if (bus.dmem_ack) begin
          state_d = ST_WB;
        end
`ifdef YSYX_23060061_MEM_TIMEOUT_EN
        else if (wait_expired_c) begin
          state_d = ST_FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
`endif
      end
      ST_WB: begin
        pc_we_c  = 1'b1;
        reg_we_c = bus.dec_reg_write & ~bus.dec_mem_write;
        retire_d = retire_q + RETIRE_W'(1);
        state_d  = ST_FETCH;
`ifdef YSYX_23060061_MEM_TIMEOUT_EN
        wait_d   = '0;
`endif
      end
      ST_HALT: begin
        halt_c = 1'b1;
      end
`ifdef YSYX_23060061_MEM_TIMEOUT_EN
      ST_FAULT: begin
        fault_c = 1'b1;
      end
`endif
      default: begin
        state_d = ST_FETCH;
`ifdef YSYX_23060061_MEM_TIMEOUT_EN
        wait_d  = '0;
`endif
      end
    endcase
  end

  // Reset masks every strobe immediately, even before the state register clears.
  assign bus.imem_req   = imem_req_c & ~rst;
  assign bus.ir_we      = ir_we_c & ~rst;
  assign bus.dmem_req   = dmem_req_c & ~rst;
  assign bus.dmem_we    = dmem_we_c & ~rst;
  assign bus.reg_we     = reg_we_c & ~rst;
  assign bus.pc_we      = pc_we_c & ~rst;
  assign bus.halt       = halt_c & ~rst;
`ifdef YSYX_23060061_MEM_TIMEOUT_EN
  assign bus.fault      = fault_c & ~rst;
`else
  assign bus.fault      = 1'b0;
`endif
  assign bus.retire_cnt = retire_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_ysyx_23060061_core_sequencer.sv
// Self-checking bench: per-instruction transaction model expands each instruction
// into expected per-cycle observations and compares them against the sequencer.
module tb_ysyx_23060061_core_sequencer;

  localparam int unsigned RW = 4;
  localparam int unsigned TO = 4;

  typedef struct packed {
    logic rst;
    logic imem_ack;
    logic dmem_ack;
    logic rw;
    logic mw;
    logic mr;
    logic eb;
  } stim_t;

  typedef struct packed {
    logic [2:0]    st;
    logic          imem_req;
    logic          ir_we;
    logic          dmem_req;
    logic          dmem_we;
    logic          reg_we;
    logic          pc_we;
    logic          halt;
    logic          fault;
    logic [RW-1:0] rc;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_23060061_core_sequencer_if #(.RETIRE_W(RW)) bus ();

  ysyx_23060061_core_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .RETIRE_W      (RW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    m_retire = 0;
  stim_t stim_q[$];
  obs_t  exp_q[$];

  function automatic stim_t rnd_stim();
    logic [6:0] r;
    stim_t s;
    r = 7'($urandom);
    s = r;
    s.rst = 1'b0;
    return s;
  endfunction

  function automatic stim_t with_dec(input stim_t d);
    stim_t s;
    s = rnd_stim();
    s.rw = d.rw;
    s.mw = d.mw;
    s.mr = d.mr;
    s.eb = d.eb;
    return s;
  endfunction

  function automatic obs_t base(input logic [2:0] st);
    obs_t o;
    o = '0;
    o.st = st;
    o.rc = RW'(m_retire);
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st       = bus.state;
    o.imem_req = bus.imem_req;
    o.ir_we    = bus.ir_we;
    o.dmem_req = bus.dmem_req;
    o.dmem_we  = bus.dmem_we;
    o.reg_we   = bus.reg_we;
    o.pc_we    = bus.pc_we;
    o.halt     = bus.halt;
    o.fault    = bus.fault;
    o.rc       = bus.retire_cnt;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("st=%0d ireq=%b irwe=%b dreq=%b dwe=%b rwe=%b pwe=%b halt=%b fault=%b rc=%0d",
                     o.st, o.imem_req, o.ir_we, o.dmem_req, o.dmem_we, o.reg_we,
                     o.pc_we, o.halt, o.fault, o.rc);
  endfunction

  task automatic apply(input stim_t s);
    @(negedge clk);
    rst               = s.rst;
    bus.imem_ack      = s.imem_ack;
    bus.dmem_ack      = s.dmem_ack;
    bus.dec_reg_write = s.rw;
    bus.dec_mem_write = s.mw;
    bus.dec_mem_read  = s.mr;
    bus.dec_ebreak    = s.eb;
    cyc++;
    #1;
  endtask

  task automatic push(input stim_t s, input obs_t o);
    stim_q.push_back(s);
    exp_q.push_back(o);
  endtask

  // Model: kind 0=alu, 1=load, 2=store, 3=ebreak; fw fetch waits, dw memory waits, hc halt cycles.
  task automatic build_instr(input int kind, input int fw, input int dw, input int hc);
    stim_t s, d;
    obs_t  o;
    d    = rnd_stim();
    d.rw = 1'($urandom_range(0, 1));
    d.mw = (kind == 2);
    d.mr = (kind == 1) || (kind == 2 && $urandom_range(0, 1) == 1);
    d.eb = (kind == 3);
    for (int i = 0; i < fw; i++) begin
      s = rnd_stim(); s.imem_ack = 1'b0;
      o = base(3'd0); o.imem_req = 1'b1;
      push(s, o);
    end
    s = rnd_stim(); s.imem_ack = 1'b1;
    o = base(3'd0); o.imem_req = 1'b1; o.ir_we = 1'b1;
    push(s, o);
    push(with_dec(d), base(3'd1));
    if (kind == 3) begin
      for (int i = 0; i < hc; i++) begin
        o = base(3'd5); o.halt = 1'b1;
        push(with_dec(d), o);
      end
      return;
    end
    push(with_dec(d), base(3'd2));
    if (d.mr || d.mw) begin
      for (int i = 0; i <= dw; i++) begin
        s = with_dec(d); s.dmem_ack = (i == dw);
        o = base(3'd3); o.dmem_req = 1'b1; o.dmem_we = d.mw;
        push(s, o);
      end
    end
    o = base(3'd4); o.pc_we = 1'b1; o.reg_we = d.rw & ~d.mw;
    push(with_dec(d), o);
    m_retire++;
  endtask

  task automatic do_reset();
    stim_t s;
    for (int i = 0; i < 2; i++) begin
      s = rnd_stim(); s.rst = 1'b1;
      apply(s);
    end
    m_retire = 0;
    stim_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    stim_t s;
    obs_t  o, e;
    s = rnd_stim(); s.rst = 1'b1; s.imem_ack = 1'b1; s.dmem_ack = 1'b1;
    apply(s);
    o = sample();
    checks++;
    if ({o.imem_req, o.ir_we, o.dmem_req, o.dmem_we, o.reg_we, o.pc_we, o.halt, o.fault} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs_low: got %s, required all strobes 0", fmt(o));
    end
    apply(s);
    m_retire = 0;
    stim_q.delete();
    exp_q.delete();
    o = sample(); e = base(3'd0);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL reset_state: got %s, required %s", fmt(o), fmt(e));
    end
    s.rst = 1'b0; s.imem_ack = 1'b0;
    apply(s);
    o = sample(); e = base(3'd0); e.imem_req = 1'b1;
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL reset_first_req: got %s, required %s", fmt(o), fmt(e));
    end
    build_instr(0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      apply(s); o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_first_instr cyc %0d: got %s, required %s", cyc, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_latency();
    stim_t s;
    obs_t  o, e;
    int    n, lat, dreq, dwe;
    do_reset();
    build_instr(0, 0, 0, 0);
    n = 0; lat = 0;
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      apply(s); o = sample(); n++;
      if (o.pc_we === 1'b1) lat = n;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL latency_alu cyc %0d: got %s, required %s", cyc, fmt(o), fmt(e));
      end
    end
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL latency_alu_cycles: got %0d, required 4", lat);
    end
    build_instr(2, 0, 3, 0);
    n = 0; lat = 0; dreq = 0; dwe = 0;
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      apply(s); o = sample(); n++;
      if (o.pc_we === 1'b1) lat = n;
      if (o.dmem_req === 1'b1) dreq++;
      if (o.dmem_req === 1'b1 && o.dmem_we === 1'b1) dwe++;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL latency_store cyc %0d: got %s, required %s", cyc, fmt(o), fmt(e));
      end
    end
    checks++;
    if (lat !== 8 || dreq !== 4 || dwe !== 4) begin
      failures++;
      $display("FAIL latency_store_cycles: got total=%0d dreq=%0d dwe=%0d, required 8/4/4", lat, dreq, dwe);
    end
  endtask

  task automatic test_random_mix();
    stim_t s;
    obs_t  o, e;
    for (int i = 0; i < 30; i++)
      build_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      apply(s); o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL random_mix cyc %0d: got %s, required %s", cyc, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    obs_t  o, e;
    for (int i = 0; i < 12; i++)
      build_instr(int'($urandom_range(0, 2)), 0, 0, 0);
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      apply(s); o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL back_to_back cyc %0d: got %s, required %s", cyc, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_wrap();
    stim_t s;
    obs_t  o, e;
    do_reset();
    for (int i = 0; i < 16; i++)
      build_instr(0, int'($urandom_range(0, 1)), 0, 0);
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      apply(s); o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL wrap_seq cyc %0d: got %s, required %s", cyc, fmt(o), fmt(e));
      end
    end
    s = rnd_stim(); s.imem_ack = 1'b0;
    apply(s); o = sample();
    checks++;
    if (o.rc !== 4'd0 || o.st !== 3'd0) begin
      failures++;
      $display("FAIL wrap_to_zero: got rc=%0d st=%0d, required rc=0 st=0", o.rc, o.st);
    end
  endtask

  task automatic test_reset_in_mem();
    stim_t s;
    obs_t  o, e;
    int    mem_seen;
    build_instr(0, 0, 0, 0);
    build_instr(0, 0, 0, 0);
    build_instr(2, 0, 10, 0);
    mem_seen = 0;
    while (exp_q.size() > 0 && mem_seen < 2) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      apply(s); o = sample();
      if (e.st == 3'd3) mem_seen++;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL mem_reset_pre cyc %0d: got %s, required %s", cyc, fmt(o), fmt(e));
      end
    end
    stim_q.delete();
    exp_q.delete();
    s = rnd_stim(); s.rst = 1'b1; s.dmem_ack = 1'b0;
    apply(s); o = sample();
    checks++;
    if (o.dmem_req !== 1'b0 || o.dmem_we !== 1'b0) begin
      failures++;
      $display("FAIL mem_reset_drop: got dreq=%b dwe=%b, required 0/0", o.dmem_req, o.dmem_we);
    end
    m_retire = 0;
    s = rnd_stim(); s.imem_ack = 1'b0;
    apply(s); o = sample(); e = base(3'd0); e.imem_req = 1'b1;
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL mem_reset_after: got %s, required %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_halt();
    stim_t s;
    obs_t  o, e;
    build_instr(0, 1, 0, 0);
    build_instr(3, int'($urandom_range(0, 2)), 0, 20);
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      apply(s); o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL halt cyc %0d: got %s, required %s", cyc, fmt(o), fmt(e));
      end
    end
    do_reset();
  endtask

  task automatic test_timeout();
    stim_t s;
    obs_t  o, e;
    do_reset();
`ifdef YSYX_23060061_MEM_TIMEOUT_EN
    for (int i = 0; i < int'(TO) + 6; i++) begin
      s = rnd_stim();
      if (i < int'(TO)) begin
        s.imem_ack = 1'b0;
        e = base(3'd0); e.imem_req = 1'b1;
      end else begin
        e = base(3'd6); e.fault = 1'b1;
      end
      apply(s); o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL timeout_fault step %0d: got %s, required %s", i, fmt(o), fmt(e));
      end
    end
`else
    for (int i = 0; i < 300; i++) begin
      s = rnd_stim(); s.imem_ack = 1'b0;
      e = base(3'd0); e.imem_req = 1'b1;
      apply(s); o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL unbounded_wait step %0d: got %s, required %s", i, fmt(o), fmt(e));
      end
    end
`endif
    do_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_latency();
    test_random_mix();
    test_back_to_back();
    test_wrap();
    test_reset_in_mem();
    test_halt();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_23060061_core_sequencer.md
YSYX_23060061_CORE_SEQUENCER -- requirements
Module: ysyx_23060061_core_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, memory-wait cycles before fault (used only with YSYX_23060061_MEM_TIMEOUT_EN).
REQ-002 Parameter: RETIRE_W, 32, width of retired-instruction counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  instruction fetch request, held until imem_ack.
REQ-006 imem_ack  input  1  fetch complete; instruction valid this cycle.
REQ-007 ir_we  output  1  one-cycle pulse latching fetched instruction into IR.
REQ-008 dec_reg_write  input  1  decoder RegWrite for current instruction.
REQ-009 dec_mem_write  input  1  decoder MemWrite (store).
REQ-010 dec_mem_read  input  1  load indicator (decoder WBSel selects memory).
REQ-011 dec_ebreak  input  1  decoder ebreak.
REQ-012 dmem_req  output  1  data memory request, held until dmem_ack.
REQ-013 dmem_we  output  1  write qualifier, valid while dmem_req=1.
REQ-014 dmem_ack  input  1  data access complete.
REQ-015 reg_we  output  1  register-file write enable, one-cycle pulse.
REQ-016 pc_we  output  1  PC update enable, one-cycle pulse.
REQ-017 halt  output  1  high while in HALT.
REQ-018 fault  output  1  high while in FAULT.
REQ-019 retire_cnt  output  RETIRE_W  retired instructions.
REQ-020 state  output  3  current state encoding.

Function
REQ-021 States/encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6; 7 unused -> FETCH next cycle.
REQ-022 FETCH: imem_req=1; on imem_ack=1 -> ir_we=1 same cycle, next DECODE; else stay.
REQ-023 DECODE: one cycle; dec_ebreak=1 -> HALT, else EXEC.
REQ-024 EXEC: one cycle; dec_mem_read|dec_mem_write -> MEM, else WB.
REQ-025 MEM: dmem_req=1, dmem_we=dec_mem_write; both read and write set -> treated as write; dmem_ack=1 -> WB.
REQ-026 WB: pc_we=1, reg_we=dec_reg_write & ~dec_mem_write, retire_cnt+1 (wraps to 0 at max), next FETCH.
REQ-027 HALT: absorbing until rst; no requests, no enables, retire_cnt frozen; ebreak not counted.
REQ-028 All outputs are decoded from registered state (Moore) except ir_we, combinationally gated by imem_ack in FETCH.
REQ-029 imem_ack outside FETCH and dmem_ack outside MEM ignored.
REQ-030 Decoder inputs stable DECODE through WB; sampled at DECODE (ebreak), EXEC (mem), MEM/WB (write qualifiers).
REQ-031 Latency: non-memory instruction with zero-wait ack = 4 cycles; load/store with zero-wait ack = 5 cycles.

Reset
REQ-032 rst=1 at any edge, any state (incl. mid-MEM) -> state=FETCH, retire_cnt=0, timeout counter=0.
REQ-033 While rst=1: imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, halt, fault all 0.
REQ-034 First imem_req asserted in the cycle after rst deasserts.

Configuration
REQ-035 Macro YSYX_23060061_MEM_TIMEOUT_EN defined: 8-bit wait counter cleared on entry to FETCH/MEM, increments per waiting cycle without ack; reaching TIMEOUT_CYCLES -> FAULT (absorbing until rst, fault=1, requests dropped).
REQ-036 Macro undefined: no counter, waits unbounded, fault tied 0, state never 6.

Verification
REQ-037 addi, imem_ack same cycle as req -> states 0,1,2,4,0; reg_we=1 and pc_we=1 at cycle 4; retire_cnt=1.
REQ-038 store, dmem_ack after 3 wait cycles -> dmem_req=1 and dmem_we=1 for 4 cycles, reg_we=0 in WB, total 8 cycles.
REQ-039 ebreak fetched -> DECODE then HALT; halt=1 persists 20 cycles, no imem_req, retire_cnt unchanged.
REQ-040 rst pulsed during MEM with dmem_req=1 -> next cycle dmem_req=0, state=0, retire_cnt=0.
REQ-041 Macro defined, TIMEOUT_CYCLES=4, imem_ack never -> fault=1 after 4 waiting cycles, state=6, imem_req=0; undefined -> imem_req stays 1.
REQ-042 RETIRE_W=4, retire 16 non-memory instructions -> retire_cnt wraps 15 -> 0.
